// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode/state enums and opcode width for multicycle_alu
package alu_pkg;

  localparam int ALU_OPW = 4;

  typedef enum logic [ALU_OPW-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLT  = 4'd5,
    OP_SLL  = 4'd6,
    OP_SRL  = 4'd7,
    OP_MUL  = 4'd8,
    OP_DIVU = 4'd9,
    OP_REMU = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/multicycle_alu_if.sv
// rtl/multicycle_alu_if.sv - operation/result handshake bundle for multicycle_alu
interface multicycle_alu_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = alu_pkg::ALU_OPW
);
  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             eq;
  logic             illegal;

  modport master (
    output in_valid, op, opa, opb, out_ready,
    input  in_ready, out_valid, result, eq, illegal
  );

  modport slave (
    input  in_valid, op, opa, opb, out_ready,
    output in_ready, out_valid, result, eq, illegal
  );
endinterface

// File: rtl/iter_muldiv.sv
// rtl/iter_muldiv.sv - one-bit-per-cycle shift-add multiply and restoring divide
// Divider datapath only present when MULTICYCLE_ALU_DIV_EN is defined.
module iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);

  // x: product accumulator / partial remainder; y: multiplicand / dividend->quotient; z: multiplier / divisor
  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
`ifdef MULTICYCLE_ALU_DIV_EN
  logic             div_q, div_d, rem_q, rem_d;
  logic [WIDTH:0]   trial;
`endif

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    done   = 1'b0;
`ifdef MULTICYCLE_ALU_DIV_EN
    div_d  = div_q;
    rem_d  = rem_q;
    trial  = {x_q, y_q[WIDTH-1]} - {1'b0, z_q};
    if (start) begin
      div_d = (op == OP_DIVU) || (op == OP_REMU);
      rem_d = (op == OP_REMU);
`else
    if (start && (op == OP_MUL)) begin
`endif
      busy_d = 1'b1;
      cnt_d  = '0;
      x_d    = '0;
      y_d    = a;
      z_d    = b;
    end else if (busy_q) begin
      cnt_d = cnt_q + 1'b1;
`ifdef MULTICYCLE_ALU_DIV_EN
      if (div_q) begin
        // a zero divisor never underflows, yielding all-ones quotient and remainder = a
        if (!trial[WIDTH]) begin
          x_d = trial[WIDTH-1:0];
          y_d = {y_q[WIDTH-2:0], 1'b1};
        end else begin
          x_d = {x_q[WIDTH-2:0], y_q[WIDTH-1]};
          y_d = {y_q[WIDTH-2:0], 1'b0};
        end
      end else
`endif
      begin
        if (z_q[0]) x_d = x_q + y_q;
        y_d = {y_q[WIDTH-2:0], 1'b0};
        z_d = {1'b0, z_q[WIDTH-1:1]};
      end
      if (cnt_q == CW'(WIDTH - 1)) begin
        busy_d = 1'b0;
        done   = 1'b1;
      end
    end
  end

`ifdef MULTICYCLE_ALU_DIV_EN
  assign result = (div_q && !rem_q) ? y_d : x_d;
`else
  assign result = x_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
`ifdef MULTICYCLE_ALU_DIV_EN
      div_q  <= 1'b0;
      rem_q  <= 1'b0;
`endif
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
`ifdef MULTICYCLE_ALU_DIV_EN
      div_q  <= div_d;
      rem_q  <= rem_d;
`endif
    end
  end
endmodule

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - IDLE/BUSY/DONE ALU: single-cycle ops inline, MUL/DIVU/REMU iterative
// DIVU/REMU are illegal opcodes unless MULTICYCLE_ALU_DIV_EN is defined.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = ALU_OPW
) (
  input logic             clk,
  input logic             rst,
  multicycle_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             eq_q, eq_d, illegal_q, illegal_d;
  logic [WIDTH-1:0] single_res, md_result;
  logic             single_ill, is_multi, md_start, md_done, accept;

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    single_res = '0;
    single_ill = 1'b0;
    is_multi   = 1'b0;
    case (bus.op)
      OPW'(OP_ADD):  single_res = bus.opa + bus.opb;
      OPW'(OP_SUB):  single_res = bus.opa - bus.opb;
      OPW'(OP_AND):  single_res = bus.opa & bus.opb;
      OPW'(OP_OR):   single_res = bus.opa | bus.opb;
      OPW'(OP_XOR):  single_res = bus.opa ^ bus.opb;
      OPW'(OP_SLT):  single_res = {{(WIDTH-1){1'b0}}, $signed(bus.opa) < $signed(bus.opb)};
      OPW'(OP_SLL):  single_res = bus.opa << bus.opb[SHW-1:0];
      OPW'(OP_SRL):  single_res = bus.opa >> bus.opb[SHW-1:0];
      OPW'(OP_MUL):  is_multi = 1'b1;
`ifdef MULTICYCLE_ALU_DIV_EN
      OPW'(OP_DIVU): is_multi = 1'b1;
      OPW'(OP_REMU): is_multi = 1'b1;
`endif
      default:       single_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    eq_d      = eq_q;
    illegal_d = illegal_q;
    md_start  = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        eq_d      = (bus.opa == bus.opb);
        illegal_d = single_ill;
        if (is_multi) begin
          md_start = 1'b1;
          result_d = '0;
          state_d  = S_BUSY;
        end else begin
          result_d = single_res;
          state_d  = S_DONE;
        end
      end
      S_BUSY: if (md_done) begin
        result_d = md_result;
        state_d  = S_DONE;
      end
      S_DONE: if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      eq_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      eq_q      <= eq_d;
      illegal_q <= illegal_d;
    end
  end

  iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .op     (alu_op_e'(bus.op)),
    .a      (bus.opa),
    .b      (bus.opb),
    .done   (md_done),
    .result (md_result)
  );

  assign bus.in_ready  = (state_q == S_IDLE) && !rst;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.eq        = eq_q;
  assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - scoreboard bench for multicycle_alu (WIDTH=32)
module tb_multicycle_alu;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic         eq;
    logic         ill;
    int           lat;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   seen = 0;
  exp_t sb[$];
  exp_t cur;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multicycle_alu_if #(.WIDTH(W), .OPW(4)) bus();

  multicycle_alu #(.WIDTH(W), .OPW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input logic [3:0] op);
    if (op == 4'd8) return W + 1;
`ifdef MULTICYCLE_ALU_DIV_EN
    if (op == 4'd9 || op == 4'd10) return W + 1;
`endif
    return 1;
  endfunction

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.res = '0;
    e.ill = 1'b0;
    e.eq  = (a == b);
    e.lat = lat_of(op);
    e.acc = 0;
    case (op)
      4'd0: e.res = a + b;
      4'd1: e.res = a - b;
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a ^ b;
      4'd5: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: e.res = a << b[4:0];
      4'd7: e.res = a >> b[4:0];
      4'd8: e.res = a * b;
`ifdef MULTICYCLE_ALU_DIV_EN
      4'd9:  e.res = (b == 0) ? '1 : a / b;
      4'd10: e.res = (b == 0) ? a : a % b;
`endif
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      seen = 0;
    end else if (bus.out_valid) begin
      if (!seen) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 64'(1), 64'(0));
        end else begin
          cur = sb.pop_front();
          check("result", 64'(bus.result), 64'(cur.res));
          check("eq", 64'(bus.eq), 64'(cur.eq));
          check("illegal", 64'(bus.illegal), 64'(cur.ill));
          check("latency", 64'(cyc - cur.acc), 64'(cur.lat));
        end
        seen = 1;
      end else begin
        check("hold_result", 64'(bus.result), 64'(cur.res));
        check("hold_in_ready", 64'(bus.in_ready), 64'(0));
      end
      if (bus.out_ready) seen = 0;
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("ready_timeout", 64'(0), 64'(1));
  endtask

  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input logic ill, input int hold);
    exp_t e;
    int   n;
    wait_ready();
    if (!bus.in_ready) return;
    bus.op        = op;
    bus.opa       = a;
    bus.opb       = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    e.res = res;
    e.eq  = (a == b);
    e.ill = ill;
    e.lat = lat_of(op);
    e.acc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    // keep presenting junk while the op is in flight; none of it may be taken
    bus.op  = 4'($urandom_range(0, 15));
    bus.opa = $urandom;
    bus.opb = $urandom;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 200) begin
      check("busy_in_ready", 64'(bus.in_ready), 64'(0));
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    if (!bus.out_valid) begin
      check("valid_timeout", 64'(0), 64'(1));
      return;
    end
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("release_in_ready", 64'(bus.in_ready), 64'(1));
      check("release_out_valid", 64'(bus.out_valid), 64'(0));
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [3:0]   op;
    logic [W-1:0] a, b;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.op        = '0;
    bus.opa       = '0;
    bus.opb       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 64'(bus.in_ready), 64'(0));
    check("reset_out_valid", 64'(bus.out_valid), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", 64'(bus.in_ready), 64'(1));
    check("post_reset_result", 64'(bus.result), 64'(0));
    check("post_reset_eq", 64'(bus.eq), 64'(0));
    check("post_reset_illegal", 64'(bus.illegal), 64'(0));

    do_op(4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 0);
    do_op(4'd8, 32'h0001_0000, 32'h0001_0003, 32'h0003_0000, 1'b0, 0);
`ifdef MULTICYCLE_ALU_DIV_EN
    do_op(4'd9,  32'd100, 32'd7, 32'd14, 1'b0, 0);
    do_op(4'd10, 32'd100, 32'd7, 32'd2, 1'b0, 0);
    do_op(4'd9,  32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 0);
    do_op(4'd10, 32'd5, 32'd0, 32'd5, 1'b0, 0);
`else
    do_op(4'd9,  32'd100, 32'd7, 32'd0, 1'b1, 0);
    do_op(4'd10, 32'd100, 32'd7, 32'd0, 1'b1, 0);
`endif
    do_op(4'd5,  32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 0);
    do_op(4'd7,  32'h8000_0000, 32'h21, 32'h4000_0000, 1'b0, 0);
    do_op(4'd13, 32'd1, 32'd2, 32'd0, 1'b1, 0);
    do_op(4'd1,  32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 0);
    do_op(4'd6,  32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0);
    do_op(4'd4,  32'h5A5A, 32'h5A5A, 32'd0, 1'b0, 0);
    do_op(4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 0);
    do_op(4'd3,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 0);
    do_op(4'd15, 32'd9, 32'd9, 32'd0, 1'b1, 0);
    do_op(4'd8,  32'd7, 32'd6, 32'd42, 1'b0, 5);

    // reset during the 10th BUSY cycle of a multiply must discard it
    wait_ready();
    bus.op       = 4'd8;
    bus.opa      = 32'h1234;
    bus.opb      = 32'h5678;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_cycle_in_ready", 64'(bus.in_ready), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("mid_rst_result", 64'(bus.result), 64'(0));
    do_op(4'd0, 32'd2, 32'd3, 32'd5, 1'b0, 0);

    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case (i % 4)
        0:       b = a;
        1:       b = 32'($urandom_range(0, 9));
        default: b = $urandom;
      endcase
      e = model(op, a, b);
      do_op(op, a, b, e.res, e.ill, 0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (legal 8..64, power of two).
REQ-002 SHALL have parameter OPW, default 4, opcode width.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 SHALL have port in_valid  input  1  operand/opcode presented.
REQ-006 SHALL have port in_ready  output  1  block can accept a new operation.
REQ-007 SHALL have port op  input  OPW  operation select (encoding in REQ-012).
REQ-008 SHALL have port opa, opb  input  WIDTH each  operands; opb already muxed (reg/imm) upstream.
REQ-009 SHALL have ports out_valid  output  1 and out_ready  input  1  result handshake.
REQ-010 SHALL have port result  output  WIDTH  registered result.
REQ-011 SHALL have ports eq  output  1 (opa==opb of accepted op), illegal  output  1 (unsupported op).

Function
REQ-012 SHALL decode op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed, result 0/1), 6 SLL, 7 SRL, 8 MUL (low WIDTH bits), 9 DIVU, 10 REMU; 11..15 illegal.
REQ-013 SHALL use an FSM with states IDLE, BUSY, DONE; in_ready = (state==IDLE).
REQ-014 SHALL accept an operation on a cycle with in_valid && in_ready, capturing op, opa, opb.
REQ-015 SHALL, for ops 0-7 and illegal ops, go IDLE->DONE; out_valid high on the cycle after acceptance (latency 1).
REQ-016 SHALL, for ops 8-10, go IDLE->BUSY, iterate one bit per cycle for exactly WIDTH cycles, then enter DONE; out_valid rises WIDTH+1 cycles after acceptance.
REQ-017 SHALL implement MUL as shift-add, DIVU/REMU as unsigned restoring division.
REQ-018 SHALL, on divide-by-zero, return all-ones for DIVU and opa for REMU, with the same latency as a normal divide.
REQ-019 SHALL use shift amount opb[log2(WIDTH)-1:0]; upper opb bits ignored.
REQ-020 SHALL wrap ADD/SUB/MUL modulo 2^WIDTH; no overflow flag.
REQ-021 SHALL hold result, eq, illegal and out_valid stable while in DONE and out_ready low.
REQ-022 SHALL go DONE->IDLE on the cycle out_valid && out_ready; new input accepted no earlier than the following cycle.
REQ-023 SHALL ignore in_valid while BUSY or DONE; operands changing then have no effect.
REQ-024 SHALL set illegal=1 and result=0 for illegal ops; illegal=0 otherwise.

Reset
REQ-025 SHALL, on rst high, force state IDLE, out_valid 0, result 0, eq 0, illegal 0, iteration counter 0, regardless of state (including mid-BUSY; in-flight op discarded).
REQ-026 SHALL drive in_ready 0 during the reset cycle and 1 on the first cycle after rst falls.

Configuration
REQ-027 SHALL use macro MULTICYCLE_ALU_DIV_EN: defined -> DIVU/REMU as REQ-016..018; undefined -> ops 9/10 treated as illegal (REQ-015, REQ-024) and no divider logic synthesised.

Structure
REQ-028 SHALL place the opcode enum, FSM state enum and opcode-width constant in shared package alu_pkg.
REQ-029 SHALL implement iterative MUL/DIV in sub-module iter_muldiv (start, op, a, b -> done, result); FSM and single-cycle ops stay in multicycle_alu.

Verification (WIDTH=32)
REQ-030 SHALL check ADD 0xFFFFFFFF+1 -> result 0, eq 0, out_valid exactly 1 cycle after acceptance.
REQ-031 SHALL check MUL 0x10000*0x10003 -> 0x00030000 (low bits), out_valid 33 cycles after acceptance, in_ready 0 throughout.
REQ-032 SHALL check DIVU 100/7 -> 14, REMU 100/7 -> 2, DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5; with macro undefined DIVU -> illegal=1, result 0, latency 1.
REQ-033 SHALL check SLT 0xFFFFFFFF,1 -> 1; SRL 0x80000000 by opb=0x21 -> 0x40000000; op 13 -> illegal=1.
REQ-034 SHALL check backpressure: out_ready low 5 cycles in DONE -> result stable, in_ready 0; release -> IDLE next cycle.
REQ-035 SHALL check rst asserted mid-MUL (cycle 10 of BUSY) -> next cycle IDLE, out_valid 0, result 0; subsequent ADD 2+3 -> 5.
